// File: rtl/pc_fetch_unit_if.sv
// Signal bundle between the PC fetch unit, its next-address mux, the instruction
// memory and the decode stage. "master" is the fetch unit; "slave" is everything around it.
interface pc_fetch_unit_if;
    logic [31:0] pc_next;
    logic        instr_ready;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] retire_count;

    modport master (
        input  pc_next, instr_ready, imem_ack, imem_rdata,
        output imem_req, imem_addr, pc, pc4, instr, instr_valid,
               fault, fault_code, retire_count
    );

    modport slave (
        output pc_next, instr_ready, imem_ack, imem_rdata,
        input  imem_req, imem_addr, pc, pc4, instr, instr_valid,
               fault, fault_code, retire_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests the word at pc, holds it until
// decode accepts, then moves to the next PC. Misaligned PCs and memory timeouts halt it.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    // Last counter value before the timeout fires; an ack on that cycle still wins.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [1:0]  r_fault_code;
    logic [31:0] r_retire;
    logic [7:0]  r_tcnt;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic [1:0]  w_fault_code_next;
    logic [31:0] w_retire_next;
    logic [7:0]  w_tcnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= 32'h0;
            r_fault_code <= CODE_NONE;
            r_retire     <= 32'h0;
            r_tcnt       <= 8'h0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_instr      <= w_instr_next;
            r_fault_code <= w_fault_code_next;
            r_retire     <= w_retire_next;
            r_tcnt       <= w_tcnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_instr_next      = r_instr;
        w_fault_code_next = r_fault_code;
        w_retire_next     = r_retire;
        w_tcnt_next       = r_tcnt;

        case (r_state)
            S_IDLE: begin
                if (r_pc[1:0] == 2'b00) begin
                    w_state_next = S_REQ;
                    w_tcnt_next  = 8'h0;
                end else begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = CODE_MISALIGN;
                end
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    w_instr_next = bus.imem_rdata;
                    w_state_next = S_HOLD;
                end else if (r_tcnt == TMO_LAST) begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = CODE_TIMEOUT;
                end else begin
                    w_tcnt_next = r_tcnt + 8'd1;
                end
            end
            S_HOLD: begin
                // pc_next is only looked at on the accept edge.
                if (bus.instr_ready) begin
                    w_pc_next     = bus.pc_next;
                    w_retire_next = r_retire + 32'd1;
                    if (bus.pc_next[1:0] == 2'b00) begin
                        w_state_next = S_REQ;
                        w_tcnt_next  = 8'h0;
                    end else begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = CODE_MISALIGN;
                    end
                end
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req     = (r_state == S_REQ);
    assign bus.imem_addr    = r_pc;
    assign bus.pc           = r_pc;
    assign bus.pc4          = r_pc + 32'd4;
    assign bus.instr        = r_instr;
    assign bus.instr_valid  = (r_state == S_HOLD);
    assign bus.fault        = (r_state == S_FAULT);
    assign bus.fault_code   = r_fault_code;
    assign bus.retire_count = r_retire;

endmodule
